// File: rtl/serial_ctrl_slave_pkg.sv
// Shared types, default widths and the readback index helper for the
// serial control-bus slave.
package serial_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    FULL = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 7;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NUM_RB      = 8;
  localparam int DEF_RB_BASE     = 1;
  localparam int DEF_SYNC_STAGES = 2;

  // Map a register address onto a readback word index; -1 when the address
  // falls below the readback window or past its last word.
  function automatic int rb_index(input int reg_addr, input int rb_base,
                                  input int num_rb);
    if (reg_addr < rb_base || (reg_addr - rb_base) >= num_rb) begin
      return -1;
    end
    return reg_addr - rb_base;
  endfunction

endpackage

// File: rtl/serial_ctrl_slave_if.sv
// Serial pins, committed register-bus outputs and the readback words,
// bundled so the slave and its host/register-file side share one port.
interface serial_ctrl_slave_if
  import serial_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_RB = DEF_NUM_RB
);

  logic                     serial_clock;
  logic                     serial_enable;
  logic                     serial_data_in;
  logic                     serial_data_out;
  logic                     serial_data_oe;
  logic [ADDR_W-1:0]        serial_addr;
  logic [DATA_W-1:0]        serial_data;
  logic                     serial_strobe;
  logic                     frame_error;
  logic [NUM_RB*DATA_W-1:0] readback;

  modport slave (
    input  serial_clock, serial_enable, serial_data_in, readback,
    output serial_data_out, serial_data_oe, serial_addr, serial_data,
           serial_strobe, frame_error
  );

  modport master (
    output serial_clock, serial_enable, serial_data_in, readback,
    input  serial_data_out, serial_data_oe, serial_addr, serial_data,
           serial_strobe, frame_error
  );

endinterface

// File: rtl/serial_ctrl_slave_sync_edge.sv
// Multi-flop synchroniser for one asynchronous serial input, with
// rising/falling edge detection on the synchronised level.
module serial_sync_edge
  import serial_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic master_clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  // Shift the pin through the synchroniser chain and remember the last level.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall     = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/serial_ctrl_slave.sv
// Serial control-bus slave: oversamples the host's serial bus in the
// master_clk domain, commits write frames atomically with a strobe and
// shifts out a readback word on read frames.
module serial_ctrl_slave
  import serial_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_RB      = DEF_NUM_RB,
  parameter int RB_BASE     = DEF_RB_BASE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic               master_clk,
  input logic               reset,
  serial_ctrl_slave_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REG_W = ADDR_W - 1;

  logic sclk_level, sclk_rise, sclk_fall;
  logic en_level, en_rise, en_fall;
  logic [SYNC_STAGES-1:0] sdi_sync_reg;
  logic sdi_sync;

  serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .master_clk (master_clk),
    .reset      (reset),
    .async_in   (bus.serial_clock),
    .sync_out   (sclk_level),
    .rise       (sclk_rise),
    .fall       (sclk_fall)
  );

  serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_en_sync (
    .master_clk (master_clk),
    .reset      (reset),
    .async_in   (bus.serial_enable),
    .sync_out   (en_level),
    .rise       (en_rise),
    .fall       (en_fall)
  );

  // Only edges of the clock and enable matter; the levels are not needed.
  wire unused_sync_levels = ^{sclk_level, sclk_fall, en_level};

  // Data goes through the same depth as the clock so it lines up with sclk_rise.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      sdi_sync_reg <= '0;
    end else begin
      sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], bus.serial_data_in};
    end
  end

  assign sdi_sync = sdi_sync_reg[SYNC_STAGES-1];

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [ADDR_W-1:0]   addr_sr_reg;
  logic [DATA_W-1:0]   data_sr_reg;
  logic                is_read_reg;
  logic                overrun_reg;
  logic                oe_reg;
  logic [ADDR_W-1:0]   serial_addr_reg;
  logic [DATA_W-1:0]   serial_data_reg;
  logic                strobe_reg;
  logic                error_reg;

  logic [ADDR_W-1:0]   addr_shift;
  logic [DATA_W-1:0]   wdata_shift;
  logic [DATA_W-1:0]   rdata_shift;
  int                  rb_idx;
  logic [DATA_W-1:0]   rb_masked [NUM_RB];
  logic [DATA_W-1:0]   rb_word;

  assign addr_shift  = {addr_sr_reg[ADDR_W-2:0], sdi_sync};
  assign wdata_shift = {data_sr_reg[DATA_W-2:0], sdi_sync};
  assign rdata_shift = {data_sr_reg[DATA_W-2:0], 1'b0};

  // Index is taken from the address as it will look after the final bit shifts in.
  assign rb_idx = rb_index(int'(addr_shift[REG_W-1:0]), RB_BASE, NUM_RB);

  for (genvar gi = 0; gi < NUM_RB; gi++) begin : g_rb_sel
    assign rb_masked[gi] = (rb_idx == gi) ? bus.readback[gi*DATA_W +: DATA_W]
                                          : '0;
  end

  // At most one word is selected; out-of-range addresses yield zero.
  always_comb begin
    rb_word = '0;
    for (int k = 0; k < NUM_RB; k++) begin
      rb_word = rb_word | rb_masked[k];
    end
  end

  // Frame FSM: enable edges frame the transfer, sclk_rise advances the bit count.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      addr_sr_reg     <= '0;
      data_sr_reg     <= '0;
      is_read_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      oe_reg          <= 1'b0;
      serial_addr_reg <= '0;
      serial_data_reg <= '0;
      strobe_reg      <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      error_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en_rise) begin
            state_reg   <= ADDR;
            cnt_reg     <= '0;
            is_read_reg <= 1'b0;
            overrun_reg <= 1'b0;
          end
        end
        ADDR: begin
          if (en_fall) begin
            state_reg <= IDLE;
            oe_reg    <= 1'b0;
            error_reg <= 1'b1;
          end else if (sclk_rise) begin
            addr_sr_reg <= addr_shift;
            if (cnt_reg == CNT_W'(ADDR_W - 1)) begin
              state_reg   <= DATA;
              cnt_reg     <= '0;
              is_read_reg <= addr_shift[ADDR_W-1];
              oe_reg      <= addr_shift[ADDR_W-1];
              data_sr_reg <= addr_shift[ADDR_W-1] ? rb_word : '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (en_fall) begin
            state_reg <= IDLE;
            oe_reg    <= 1'b0;
            error_reg <= 1'b1;
          end else if (sclk_rise) begin
            data_sr_reg <= is_read_reg ? rdata_shift : wdata_shift;
            if (cnt_reg == CNT_W'(DATA_W - 1)) begin
              state_reg <= FULL;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        FULL: begin
          if (en_fall) begin
            state_reg <= IDLE;
            oe_reg    <= 1'b0;
            if (overrun_reg) begin
              error_reg <= 1'b1;
            end else if (!is_read_reg) begin
              serial_addr_reg <= addr_sr_reg;
              serial_data_reg <= data_sr_reg;
              strobe_reg      <= 1'b1;
            end
          end else if (sclk_rise) begin
            overrun_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.serial_data_oe  = oe_reg;
  assign bus.serial_data_out = oe_reg & data_sr_reg[DATA_W-1];
  assign bus.serial_addr     = serial_addr_reg;
  assign bus.serial_data     = serial_data_reg;
  assign bus.serial_strobe   = strobe_reg;
  assign bus.frame_error     = error_reg;

endmodule

// File: tb/tb_serial_ctrl_slave.sv
// Self-checking bench for serial_ctrl_slave: a table of directed frames,
// a reset-mid-read sequence, then randomized frames against a frame-level
// model. Override the parameters (e.g. ADDR_W=8, DATA_W=16, NUM_RB=4) to
// rerun every case in another configuration.
module tb_serial_ctrl_slave;

  parameter int ADDR_W      = 7;
  parameter int DATA_W      = 32;
  parameter int NUM_RB      = 8;
  parameter int RB_BASE     = 1;
  parameter int SYNC_STAGES = 2;

  localparam int REG_W  = ADDR_W - 1;
  localparam int FULL_N = ADDR_W + DATA_W;
  localparam int H      = SYNC_STAGES + 2;   // serial clock half period, master cycles

  logic master_clk = 1'b0;
  logic reset      = 1'b1;

  serial_ctrl_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RB(NUM_RB)) bus_if ();

  serial_ctrl_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RB(NUM_RB),
    .RB_BASE(RB_BASE), .SYNC_STAGES(SYNC_STAGES)
  ) u_dut (
    .master_clk (master_clk),
    .reset      (reset),
    .bus        (bus_if)
  );

  always #5 master_clk = ~master_clk;

  logic [DATA_W-1:0] rb_mem [NUM_RB];

  always_comb begin
    bus_if.readback = '0;
    for (int k = 0; k < NUM_RB; k++) begin
      bus_if.readback[k*DATA_W +: DATA_W] = rb_mem[k];
    end
  end

  // Pulse counters sampled away from the active edge.
  int strobe_cnt = 0;
  int err_cnt    = 0;
  always @(negedge master_clk) begin
    if (bus_if.serial_strobe) strobe_cnt++;
    if (bus_if.frame_error) err_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Model of what the host reads back for a register address.
  function automatic logic [DATA_W-1:0] model_word(input int reg_a);
    if (reg_a >= RB_BASE && reg_a < RB_BASE + NUM_RB) return rb_mem[reg_a - RB_BASE];
    return '0;
  endfunction

  // One serial clock period with data presented at the rising edge.
  task automatic clock_bit(input logic b);
    bus_if.serial_data_in = b;
    bus_if.serial_clock   = 1'b1;
    repeat (H) @(negedge master_clk);
    bus_if.serial_clock = 1'b0;
    repeat (H) @(negedge master_clk);
  endtask

  task automatic run_frame(input logic rd, input int reg_a, input logic [DATA_W-1:0] wdata,
                           input int n_rises, output logic [DATA_W-1:0] cap,
                           output int oe_low, output int n_strobe, output int n_err,
                           output int lat);
    logic [ADDR_W-1:0] addr_word;
    logic b;
    int s0, e0;
    addr_word = {rd, REG_W'(reg_a)};
    s0 = strobe_cnt;
    e0 = err_cnt;
    cap = '0;
    oe_low = 0;
    lat = 0;
    bus_if.serial_enable = 1'b1;
    repeat (H) @(negedge master_clk);
    for (int k = 0; k < n_rises; k++) begin
      if (k < ADDR_W) b = addr_word[ADDR_W-1-k];
      else if (k < FULL_N) b = wdata[FULL_N-1-k];
      else b = 1'($urandom_range(0, 1));
      bus_if.serial_data_in = b;
      bus_if.serial_clock   = 1'b1;
      repeat (H) @(negedge master_clk);
      // Host samples read data just before its falling edge.
      if (k >= ADDR_W - 1 && k <= FULL_N - 2) begin
        cap = {cap[DATA_W-2:0], bus_if.serial_data_out};
        if (bus_if.serial_data_oe !== 1'b1) oe_low++;
      end
      bus_if.serial_clock = 1'b0;
      repeat (H) @(negedge master_clk);
    end
    bus_if.serial_enable = 1'b0;
    for (int i = 1; i <= SYNC_STAGES + 6; i++) begin
      @(negedge master_clk);
      if (bus_if.serial_strobe === 1'b1 && lat == 0) lat = i;
    end
    n_strobe = strobe_cnt - s0;
    n_err    = err_cnt - e0;
  endtask

  typedef struct {
    logic        rd;
    int          reg_a;
    logic [63:0] wdata;
    int          n_rises;
    int          exp_strobe;
    int          exp_err;
    logic [63:0] exp_rdata;
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic set_vec(input int i, input logic rd, input int reg_a, input logic [63:0] wd,
                         input int n, input int es, input int ee, input logic [63:0] erd,
                         input logic [63:0] ea, input logic [63:0] ed);
    vecs[i].rd = rd;         vecs[i].reg_a = reg_a;    vecs[i].wdata = wd;
    vecs[i].n_rises = n;     vecs[i].exp_strobe = es;  vecs[i].exp_err = ee;
    vecs[i].exp_rdata = erd; vecs[i].exp_addr = ea;    vecs[i].exp_data = ed;
  endtask

  logic [DATA_W-1:0] cap;
  int oe_low, n_strobe, n_err, lat;
  logic [63:0] model_addr, model_data;
  logic [63:0] dead, a5, ff;
  int top_reg;

  initial begin
    bus_if.serial_clock   = 1'b0;
    bus_if.serial_enable  = 1'b0;
    bus_if.serial_data_in = 1'b0;
    for (int k = 0; k < NUM_RB; k++) rb_mem[k] = DATA_W'($urandom());
    rb_mem[2] = DATA_W'(32'h1234_5678);
    repeat (5) @(negedge master_clk);
    reset = 1'b0;
    @(negedge master_clk);

    check("reset_addr",   64'(bus_if.serial_addr), 64'd0);
    check("reset_data",   64'(bus_if.serial_data), 64'd0);
    check("reset_strobe", 64'(bus_if.serial_strobe), 64'd0);
    check("reset_err",    64'(bus_if.frame_error), 64'd0);
    check("reset_oe",     64'(bus_if.serial_data_oe), 64'd0);
    check("reset_dout",   64'(bus_if.serial_data_out), 64'd0);

    dead = 64'(DATA_W'(32'hDEAD_BEEF));
    a5   = 64'(DATA_W'(32'hA5C3_3C5A));
    ff   = 64'(DATA_W'(32'h0000_00FF));
    top_reg = (1 << REG_W) - 1;

    //      i  rd    reg                    wdata  n rises        st er rdata                    addr  data
    set_vec(0, 1'b0, 5,                     dead,  FULL_N,        1, 0, 0,                       5,    dead);
    set_vec(1, 1'b1, 3,                     0,     FULL_N,        0, 0, 64'(rb_mem[2]),          5,    dead);
    set_vec(2, 1'b1, 'h0F,                  0,     FULL_N,        0, 0, 0,                       5,    dead);
    set_vec(3, 1'b0, 9,                     a5,    ADDR_W + 20,   0, 1, 0,                       5,    dead);
    set_vec(4, 1'b0, 'h0A,                  a5,    FULL_N + 2,    0, 1, 0,                       5,    dead);
    set_vec(5, 1'b1, RB_BASE,               0,     FULL_N,        0, 0, 64'(rb_mem[0]),          5,    dead);
    set_vec(6, 1'b1, RB_BASE + NUM_RB - 1,  0,     FULL_N,        0, 0, 64'(rb_mem[NUM_RB-1]),   5,    dead);
    set_vec(7, 1'b1, 0,                     0,     FULL_N,        0, 0, 0,                       5,    dead);
    set_vec(8, 1'b1, RB_BASE + NUM_RB,      0,     FULL_N,        0, 0, 0,                       5,    dead);
    set_vec(9, 1'b0, top_reg,               a5,    FULL_N,        1, 0, 0,                       64'(top_reg), a5);
    set_vec(10, 1'b0, 4,                    dead,  3,             0, 1, 0,                       64'(top_reg), a5);
    set_vec(11, 1'b1, RB_BASE,              0,     FULL_N + 1,    0, 1, 0,                       64'(top_reg), a5);

    for (int i = 0; i < NV; i++) begin
      run_frame(vecs[i].rd, vecs[i].reg_a, DATA_W'(vecs[i].wdata), vecs[i].n_rises,
                cap, oe_low, n_strobe, n_err, lat);
      $display("vec %0d rd=%0b reg=%0h rises=%0d strobes=%0d errors=%0d cap=%0h",
               i, vecs[i].rd, vecs[i].reg_a, vecs[i].n_rises, n_strobe, n_err, cap);
      check($sformatf("vec%0d_strobe", i), 64'(n_strobe), 64'(vecs[i].exp_strobe));
      check($sformatf("vec%0d_err", i),    64'(n_err),    64'(vecs[i].exp_err));
      check($sformatf("vec%0d_addr", i),   64'(bus_if.serial_addr), vecs[i].exp_addr);
      check($sformatf("vec%0d_data", i),   64'(bus_if.serial_data), vecs[i].exp_data);
      check($sformatf("vec%0d_oe_end", i), 64'(bus_if.serial_data_oe), 64'd0);
      if (vecs[i].rd && vecs[i].n_rises == FULL_N) begin
        check($sformatf("vec%0d_rdata", i),  64'(cap), vecs[i].exp_rdata);
        check($sformatf("vec%0d_oe_low", i), 64'(oe_low), 64'd0);
      end
      if (i == 0) check("strobe_latency", 64'(lat), 64'(SYNC_STAGES + 1));
      repeat (2 * SYNC_STAGES + 4) @(negedge master_clk);
    end

    // Reset in the middle of a read frame.
    begin
      logic [ADDR_W-1:0] aw;
      int s0, e0;
      aw = {1'b1, REG_W'(RB_BASE)};
      s0 = strobe_cnt;
      e0 = err_cnt;
      bus_if.serial_enable = 1'b1;
      repeat (H) @(negedge master_clk);
      for (int k = 0; k < ADDR_W; k++) clock_bit(aw[ADDR_W-1-k]);
      check("midread_oe_before", 64'(bus_if.serial_data_oe), 64'd1);
      for (int k = 0; k < 5; k++) clock_bit(1'b0);
      reset = 1'b1;
      @(negedge master_clk);
      check("midread_oe_after_reset", 64'(bus_if.serial_data_oe), 64'd0);
      bus_if.serial_enable = 1'b0;
      bus_if.serial_clock  = 1'b0;
      repeat (4) @(negedge master_clk);
      reset = 1'b0;
      repeat (2 * SYNC_STAGES + 4) @(negedge master_clk);
      check("midread_no_strobe", 64'(strobe_cnt - s0), 64'd0);
      check("midread_no_err",    64'(err_cnt - e0), 64'd0);
      check("midread_addr_clr",  64'(bus_if.serial_addr), 64'd0);
      $display("reset mid-read: oe=%0b addr=%0h", bus_if.serial_data_oe, bus_if.serial_addr);
      run_frame(1'b0, 1, DATA_W'(ff), FULL_N, cap, oe_low, n_strobe, n_err, lat);
      $display("post-reset write: strobes=%0d errors=%0d addr=%0h data=%0h",
               n_strobe, n_err, bus_if.serial_addr, bus_if.serial_data);
      check("postrst_strobe", 64'(n_strobe), 64'd1);
      check("postrst_err",    64'(n_err), 64'd0);
      check("postrst_addr",   64'(bus_if.serial_addr), 64'd1);
      check("postrst_data",   64'(bus_if.serial_data), ff);
      repeat (2 * SYNC_STAGES + 4) @(negedge master_clk);
    end

    // Randomized frames against the frame-level model.
    model_addr = 64'd1;
    model_data = ff;
    for (int f = 0; f < 40; f++) begin
      logic rd;
      int reg_a, n, exp_s, exp_e;
      logic [DATA_W-1:0] wd, exp_rd;
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) reg_a = int'($urandom_range(0, RB_BASE + NUM_RB + 1));
      else reg_a = int'($urandom_range(0, (1 << REG_W) - 1));
      if (reg_a > (1 << REG_W) - 1) reg_a = (1 << REG_W) - 1;
      wd = DATA_W'({$urandom(), $urandom()});
      if ($urandom_range(0, 9) < 7) n = FULL_N;
      else n = int'($urandom_range(0, FULL_N + 3));
      rb_mem[$urandom_range(0, NUM_RB - 1)] = DATA_W'($urandom());
      exp_rd = model_word(reg_a);
      exp_s = 0;
      exp_e = (n == FULL_N) ? 0 : 1;
      if (!rd && n == FULL_N) begin
        exp_s = 1;
        model_addr = 64'(reg_a);
        model_data = 64'(wd);
      end
      run_frame(rd, reg_a, wd, n, cap, oe_low, n_strobe, n_err, lat);
      $display("rand %0d rd=%0b reg=%0h rises=%0d strobes=%0d errors=%0d cap=%0h",
               f, rd, reg_a, n, n_strobe, n_err, cap);
      check($sformatf("rand%0d_strobe", f), 64'(n_strobe), 64'(exp_s));
      check($sformatf("rand%0d_err", f),    64'(n_err), 64'(exp_e));
      check($sformatf("rand%0d_addr", f),   64'(bus_if.serial_addr), model_addr);
      check($sformatf("rand%0d_data", f),   64'(bus_if.serial_data), model_data);
      if (rd && n == FULL_N) begin
        check($sformatf("rand%0d_rdata", f),  64'(cap), 64'(exp_rd));
        check($sformatf("rand%0d_oe_low", f), 64'(oe_low), 64'd0);
      end
      repeat (2 * SYNC_STAGES + 4) @(negedge master_clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_ctrl_slave.md
Name: serial_ctrl_slave

Overview:
- Parametrised successor to the Cypress serial control-bus slave.
- Oversamples the serial bus (serial_clock, serial_enable, serial_data_in) in the master_clk domain; no logic is clocked by the serial clock.
- Decodes write and read frames. Writes commit atomically, with a strobe, to the register bus. Reads shift out one of NUM_RB readback words.
- Sits between the FX2 serial pins (top level owns the tristate pad) and the register file / readback mux.

Parameters:
ADDR_W, 7, address field width; bit ADDR_W-1 is the read flag, low ADDR_W-1 bits are the register address
DATA_W, 32, data field width
NUM_RB, 8, number of readback words
RB_BASE, 1, register address mapped to readback word 0
SYNC_STAGES, 2, synchroniser depth on serial inputs (>=2)

Ports:
master_clk  in  1  system clock; all state on its rising edge
reset  in  1  synchronous, active-high
serial_clock  in  1  async serial clock from host
serial_enable  in  1  async frame enable, active-high
serial_data_in  in  1  async serial data, MSB first
serial_data_out  out  1  read data bit
serial_data_oe  out  1  pad output enable
serial_addr  out  ADDR_W  committed write address
serial_data  out  DATA_W  committed write data
serial_strobe  out  1  one-cycle pulse on write commit
frame_error  out  1  one-cycle pulse on aborted/overrun frame
readback  in  NUM_RB*DATA_W  word k at bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset values: all outputs, counters and shift registers 0; FSM in IDLE.
- Reset mid-frame discards the frame with no strobe and no error pulse.
- Input conditioning:
  - All three serial inputs pass through SYNC_STAGES flops.
  - sclk_rise = sync'd serial_clock rising; en_rise / en_fall likewise on serial_enable.
  - Data is sampled on the cycle sclk_rise is detected (same pipeline depth, so aligned).
  - Requirement: serial_clock high and low each >= SYNC_STAGES+1 master_clk cycles.
- FSM states:
  - IDLE: en_rise -> ADDR; bit counter cleared.
  - ADDR: each sclk_rise shifts a bit into addr_sr (MSB first). After ADDR_W bits -> DATA.
    - If the read flag is set, on that same cycle load data_sr = readback[idx], where idx = addr_sr[ADDR_W-2:0] - RB_BASE.
    - Out-of-range idx (underflow or >= NUM_RB) loads 0.
  - DATA, write frame: each sclk_rise shifts in serial_data_in. After DATA_W bits -> FULL.
  - DATA, read frame:
    - serial_data_oe = 1 and serial_data_out = data_sr[DATA_W-1].
    - Each sclk_rise shifts data_sr left, zero-filling. Host samples on its falling edge.
    - After DATA_W bits -> FULL.
  - FULL: further sclk_rise sets an overrun flag, and bits are ignored.
- Frame end (en_fall), from any non-IDLE state, always returns to IDLE and clears oe the next cycle:
  - FULL, write, no overrun: serial_addr <= addr_sr, serial_data <= data_sr, serial_strobe = 1, all in the same single cycle.
  - FULL, read, no overrun: no strobe, no error.
  - ADDR, DATA, or FULL with overrun: frame_error = 1 for one cycle; outputs unchanged.
- Latency: strobe rises SYNC_STAGES+1 master_clk cycles after serial_enable falls at the pin.
- serial_addr / serial_data hold their values between commits and never show partial frames.
- Simultaneous sclk_rise and en_fall in one cycle: en_fall wins and the edge is ignored.
- en_rise while not IDLE cannot occur (an en_fall always intervenes); no special handling.
- Counter width $clog2(DATA_W+1). Shifts are MSB-first for both fields.

Decomposition:
- Package serial_ctrl_pkg holds:
  - FSM state enum (IDLE, ADDR, DATA, FULL)
  - default widths
  - readback index-range helper function
- Sub-module serial_sync_edge: SYNC_STAGES-deep synchroniser plus rise/fall detect, synchronous reset. Instantiated for serial_clock and serial_enable. Data uses the plain synchroniser path.

Test Plan:
- Write frame: addr 7'h05, data 32'hDEADBEEF, sclk = master/8 -> one strobe, serial_addr=5, serial_data=DEADBEEF, frame_error=0.
- Read frame: addr 7'h43, readback word 2 = 32'h12345678 -> oe high through the data phase, host captures 12345678, no strobe.
- Read frame: addr 7'h4F (idx 14, out of range) -> host captures 0.
- Abort: enable dropped after 20 data bits of a write -> frame_error pulse, no strobe, prior serial_addr/serial_data retained.
- Overrun: 41 sclk edges in a write frame -> frame_error pulse, no strobe.
- Reset asserted mid-read -> oe=0 next cycle, FSM IDLE. Following write addr 7'h01, data 32'h0000_00FF commits correctly.
- Parametric rerun of all cases: ADDR_W=8, DATA_W=16, NUM_RB=4.
